lut_stream_reader: RTL

Parametrised sequencer that streams a contiguous address window of a single-port block-RAM LUT (e.g. blk_mem_gen_0) onto a valid/ready stream. It compensates for BRAM read latency with a credit-controlled output buffer, so downstream backpressure never loses data. It supports one-shot, continuous-loop and (optionally) ping-pong traversal, replacing free-running address counters in front of LUT memories.

---
 rtl/lut_stream_reader.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/lut_stream_reader.sv
// Streams an inclusive BRAM address window onto a valid/ready stream through a credit-limited FIFO.
// Optional ping-pong traversal is compiled in with LUTRD_PINGPONG_EN.
module lut_stream_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              CLK100MHZ,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              pingpong,
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       pass_cnt
);
    localparam int FIFO_D = RD_LAT + 2;
    localparam int PTR_W  = $clog2(FIFO_D);
    localparam int CNT_W  = $clog2(FIFO_D + RD_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic              flush;
    logic              dir_down;
    logic [ADDR_W-1:0] lo_r;
    logic [ADDR_W-1:0] hi_r;
    logic              loop_r;
    logic              pp_r;

    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] last_p;

    logic [DATA_W-1:0] fifo_data [FIFO_D];
    logic              fifo_last [FIFO_D];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic [CNT_W-1:0]  in_flight;
    logic [CNT_W-1:0]  inflight_nxt;
    logic [CNT_W-1:0]  fifo_nxt;
    logic              ret;
    logic              stop_now;
    logic              pop;
    logic              push;
    logic              issue;
    logic              drain_done;
    logic              pass_end;
    logic              issue_last;
    logic [ADDR_W-1:0] nxt_addr;
    logic              nxt_down;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + CNT_W'(vld_p[i]);
        end
    end

    assign ret      = vld_p[RD_LAT-1];
    assign stop_now = stop && (state != S_IDLE);
    assign m_valid  = (fifo_cnt != '0);
    assign m_data   = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last   = m_valid && fifo_last[rd_ptr];
    assign pop      = m_valid && m_ready;
    // Returns landing while a stop is being honoured or flushed are dropped on the floor.
    assign push     = ret && !flush && !stop_now;
    assign issue    = (state == S_RUN) &&
                      ((in_flight + fifo_cnt - CNT_W'(pop)) < CNT_W'(FIFO_D));
    assign bram_en  = issue;
    assign busy     = (state != S_IDLE);

    assign inflight_nxt = in_flight - CNT_W'(ret) + CNT_W'(issue);
    assign fifo_nxt     = stop_now ? '0 : fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    assign drain_done   = (inflight_nxt == '0) && (fifo_nxt == '0);

    // Traversal step for the address currently on bram_addr.
    always_comb begin
        nxt_addr   = bram_addr;
        nxt_down   = dir_down;
        pass_end   = 1'b0;
        issue_last = 1'b0;
        if (!dir_down) begin
            if (bram_addr == hi_r) begin
                if (pp_r && (lo_r != hi_r)) begin
                    nxt_addr = hi_r - ADDR_W'(1);
                    nxt_down = 1'b1;
                end else begin
                    pass_end = 1'b1;
                end
            end else begin
                nxt_addr = bram_addr + ADDR_W'(1);
            end
        end else if (bram_addr == lo_r) begin
            pass_end = 1'b1;
        end else begin
            nxt_addr = bram_addr - ADDR_W'(1);
        end
        if (pass_end) begin
            issue_last = 1'b1;
            nxt_addr   = lo_r;
            nxt_down   = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            flush     <= 1'b0;
            dir_down  <= 1'b0;
            bram_addr <= '0;
            vld_p     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_cnt  <= '0;
            pass_cnt  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // Read-latency tag pipeline
            vld_p[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end

            // Output FIFO
            if (stop_now) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_cnt <= fifo_nxt;
            if (pop && m_last) pass_cnt <= sat_inc16(pass_cnt);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (addr_lo <= addr_hi) begin
                            state     <= S_RUN;
                            bram_addr <= addr_lo;
                            dir_down  <= 1'b0;
                            pass_cnt  <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop_now) begin
                        state <= S_DRAIN;
                        flush <= 1'b1;
                    end else if (issue) begin
                        bram_addr <= nxt_addr;
                        dir_down  <= nxt_down;
                        if (pass_end && !loop_r) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (stop_now) flush <= 1'b1;
                    if (drain_done) begin
                        state <= S_IDLE;
                        flush <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Window configuration and data-path storage carry no reset.
    always_ff @(posedge CLK100MHZ) begin
        if ((state == S_IDLE) && start) begin
            lo_r   <= addr_lo;
            hi_r   <= addr_hi;
            loop_r <= loop;
`ifdef LUTRD_PINGPONG_EN
            pp_r   <= pingpong;
`else
            pp_r   <= 1'b0;
`endif
        end
        last_p[0] <= issue_last;
        for (int i = 1; i < RD_LAT; i++) begin
            last_p[i] <= last_p[i-1];
        end
        if (push) begin
            fifo_data[wr_ptr] <= bram_dout;
            fifo_last[wr_ptr] <= last_p[RD_LAT-1];
        end
    end

`ifndef LUTRD_PINGPONG_EN
    logic unused_pingpong;
    assign unused_pingpong = pingpong;
`endif

endmodule
